pwm_audio_dac: RTL

//   Multi-channel PWM audio DAC; next generation of the single-channel 8-bit PWM output stage.

---
 rtl/audio_pkg.sv | 20 ++
 rtl/pwm_channel.sv | 30 +++
 rtl/pwm_audio_dac.sv | 89 ++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared defaults and helpers for the multi-channel PWM audio DAC.
// The duty helper is the single definition of the sample-to-duty mapping.
package audio_pkg;

    localparam int DEF_NCH      = 2;
    localparam int DEF_SAMPLE_W = 8;
    localparam int DEF_PERIOD   = 12500;
    localparam int DEF_SCALE    = 49;
    localparam int UCNT_W       = 16;

    typedef logic [DEF_SAMPLE_W-1:0] sample_t;

    // The product stays at 32 bits so the shift never drops high bits.
    function automatic int unsigned scaled_duty(input int unsigned sample,
                                                input int unsigned scale,
                                                input logic [2:0]  vol);
        return (sample * scale) >> vol;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM output: duty register loaded at the period boundary,
// comparator against the shared period counter, mute gate and output flop.
module pwm_channel #(
    parameter int CNT_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W:0]   duty_next,
    input  logic [CNT_W-1:0] cnt,
    input  logic             mute,
    output logic             pwm
);

    // One extra bit so a duty equal to the full period is representable.
    logic [CNT_W:0] duty;

    always_ff @(posedge clk) begin
        if (rst) begin
            duty <= '0;
            pwm  <= 1'b0;
        end else begin
            if (load) begin
                duty <= duty_next;
            end
            pwm <= !mute && ({1'b0, cnt} < duty);
        end
    end

endmodule

// File: rtl/pwm_audio_dac.sv
// Multi-channel PWM audio DAC: period counter, 1-deep frame buffer,
// sample handshake, underrun tracking and one pwm_channel per pin.
module pwm_audio_dac
    import audio_pkg::*;
#(
    parameter int NCH      = DEF_NCH,
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int PERIOD   = DEF_PERIOD,
    parameter int SCALE    = DEF_SCALE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NCH*SAMPLE_W-1:0] in_sample,
    input  logic [2:0]              vol,
    input  logic                    mute,
    output logic [NCH-1:0]          pwm,
    output logic                    period_tick,
    output logic                    underrun,
    output logic [UCNT_W-1:0]       underrun_cnt
);

    localparam int              CNT_W = $clog2(PERIOD);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    if (SCALE * (2**SAMPLE_W - 1) > PERIOD) begin : g_scale_check
        $error("pwm_audio_dac: SCALE * max sample exceeds PERIOD");
    end

    logic [CNT_W-1:0]        cnt;
    logic                    boundary;
    logic                    buf_full;
    logic [NCH*SAMPLE_W-1:0] frame_buf;
    logic                    xfer;
    logic                    load;

    // Handshake: a frame transfers on any cycle where in_valid && in_ready.
    // in_ready is high while the buffer is empty, and also on the boundary
    // cycle, where the buffered frame moves into the duty registers and the
    // slot frees up in the same edge. in_valid may drop without a transfer.
    assign boundary    = (cnt == LAST);
    assign period_tick = boundary;
    assign in_ready    = !buf_full || boundary;
    assign xfer        = in_valid && in_ready;
    assign load        = boundary && buf_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            buf_full     <= 1'b0;
            frame_buf    <= '0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            cnt      <= boundary ? '0 : cnt + CNT_W'(1);
            underrun <= boundary && !buf_full;
            if (boundary && !buf_full && (underrun_cnt != '1)) begin
                underrun_cnt <= underrun_cnt + UCNT_W'(1);
            end
            if (xfer) begin
                frame_buf <= in_sample;
                buf_full  <= 1'b1;
            end else if (load) begin
                buf_full <= 1'b0;
            end
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [CNT_W:0] duty_next;

        assign duty_next = (CNT_W + 1)'(scaled_duty(32'(frame_buf[c*SAMPLE_W +: SAMPLE_W]),
                                                    32'(SCALE), vol));

        pwm_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .load      (load),
            .duty_next (duty_next),
            .cnt       (cnt),
            .mute      (mute),
            .pwm       (pwm[c])
        );
    end

endmodule
